// File: rtl/pc_unit.sv
// Program counter for the MIPS fetch stage. It supports prioritised redirects,
// 4-byte alignment checking and a circular return-address stack.
module pc_unit #(
  parameter int               WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(32'h0000_0000),
  parameter logic [WIDTH-1:0] EXC_VECTOR   = WIDTH'(32'h0000_0180),
  parameter int               RAS_DEPTH    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             exception,
  input  logic             jump,
  input  logic [WIDTH-1:0] jump_target,
  input  logic             call,
  input  logic             ret,
  input  logic             branch,
  input  logic [WIDTH-1:0] branch_offset,
  input  logic             pc_write,
  input  logic [WIDTH-1:0] pc_write_value,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus4,
  output logic             ras_empty,
  output logic             ras_full,
  output logic             ras_overflow,
  output logic             ras_underflow,
  output logic             misaligned
);

  localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int CNT_W = $clog2(RAS_DEPTH + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RAS_DEPTH);

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [PTR_W-1:0] ptr_q, ptr_d, ptr_inc;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] ras_q [RAS_DEPTH];
  logic [WIDTH-1:0] ras_d [RAS_DEPTH];
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             mis_q, mis_d;
  logic [WIDTH-1:0] raw_target;
  logic             load_target;

  assign pc_plus4      = pc_q + WIDTH'(4);
  assign pc            = pc_q;
  assign ras_empty     = (cnt_q == '0);
  assign ras_full      = (cnt_q == CNT_MAX);
  assign ras_overflow  = ovf_q;
  assign ras_underflow = unf_q;
  assign misaligned    = mis_q;
  assign ptr_inc       = ptr_q + PTR_W'(1);

  always_comb begin
    pc_d        = pc_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    ras_d       = ras_q;
    ovf_d       = ovf_q;
    unf_d       = unf_q;
    mis_d       = 1'b0;
    raw_target  = '0;
    load_target = 1'b0;

    if (exception) begin
      pc_d = EXC_VECTOR;
    end else if (stall) begin
      pc_d = pc_q;
    end else if (ret) begin
      if (cnt_q == '0) begin
        pc_d  = pc_plus4;
        unf_d = 1'b1;
      end else begin
        // Popped slots are zeroed so unused entries never hold stale data.
        raw_target    = ras_q[ptr_q];
        load_target   = 1'b1;
        ras_d[ptr_q]  = '0;
        ptr_d         = ptr_q - PTR_W'(1);
        cnt_d         = cnt_q - CNT_W'(1);
      end
    end else if (jump) begin
      raw_target  = jump_target;
      load_target = 1'b1;
      if (call) begin
        // When full, ptr_inc lands on the oldest entry and overwrites it.
        ptr_d          = ptr_inc;
        ras_d[ptr_inc] = pc_plus4;
        if (cnt_q == CNT_MAX) ovf_d = 1'b1;
        else                  cnt_d = cnt_q + CNT_W'(1);
      end
    end else if (branch) begin
      raw_target  = pc_q + branch_offset;
      load_target = 1'b1;
    end else if (pc_write) begin
      raw_target  = pc_write_value;
      load_target = 1'b1;
    end else begin
      pc_d = pc_plus4;
    end

    if (load_target) begin
      pc_d  = {raw_target[WIDTH-1:2], 2'b00};
      mis_d = |raw_target[1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q  <= RESET_VECTOR;
      ptr_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
      mis_q <= 1'b0;
      for (int i = 0; i < RAS_DEPTH; i++) ras_q[i] <= '0;
    end else begin
      pc_q  <= pc_d;
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
      mis_q <= mis_d;
      for (int i = 0; i < RAS_DEPTH; i++) ras_q[i] <= ras_d[i];
    end
  end

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit: it walks through reset, the priority order, the RAS,
// alignment, wrap-around and asynchronous reset, using hand-computed expectations.
module tb_pc_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, exception, jump, call, ret, branch, pc_write;
  logic [31:0] jump_target, branch_offset, pc_write_value;
  logic [31:0] pc, pc_plus4;
  logic        ras_empty, ras_full, ras_overflow, ras_underflow, misaligned;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pc_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall          (stall),
    .exception      (exception),
    .jump           (jump),
    .jump_target    (jump_target),
    .call           (call),
    .ret            (ret),
    .branch         (branch),
    .branch_offset  (branch_offset),
    .pc_write       (pc_write),
    .pc_write_value (pc_write_value),
    .pc             (pc),
    .pc_plus4       (pc_plus4),
    .ras_empty      (ras_empty),
    .ras_full       (ras_full),
    .ras_overflow   (ras_overflow),
    .ras_underflow  (ras_underflow),
    .misaligned     (misaligned)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    stall = 0; exception = 0; jump = 0; call = 0; ret = 0; branch = 0; pc_write = 0;
    jump_target = '0; branch_offset = '0; pc_write_value = '0;
  endtask

  // Advance one clock; inputs are changed and outputs sampled 1 time unit after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_call(input logic [31:0] target);
    clear_inputs(); jump = 1; call = 1; jump_target = target; cyc();
  endtask

  task automatic do_ret();
    clear_inputs(); ret = 1; cyc();
  endtask

  initial begin
    clear_inputs();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_pc", pc, 32'h0);
    chk("reset_pc_plus4", pc_plus4, 32'h4);
    chk("reset_ras_empty", 32'(ras_empty), 32'd1);
    chk("reset_ras_full", 32'(ras_full), 32'd0);
    chk("reset_flags", {29'd0, ras_overflow, ras_underflow, misaligned}, 32'd0);
    rst_n = 1;

    cyc(); chk("idle_1", pc, 32'h4);
    cyc(); chk("idle_2", pc, 32'h8);
    cyc(); chk("idle_3", pc, 32'hC);

    clear_inputs(); pc_write = 1; pc_write_value = 32'h100; cyc();
    chk("pc_write_100", pc, 32'h100);
    clear_inputs(); branch = 1; branch_offset = 32'hFFFF_FFF0; cyc();
    chk("branch_negative", pc, 32'hF0);
    clear_inputs(); branch = 1; branch_offset = 32'h10; pc_write = 1; pc_write_value = 32'h500; cyc();
    chk("branch_over_write", pc, 32'h100);
    clear_inputs(); branch = 1; branch_offset = 32'h10; stall = 1; cyc();
    chk("stall_over_branch", pc, 32'h100);

    clear_inputs(); pc_write = 1; pc_write_value = 32'h40; cyc();
    chk("pc_write_40", pc, 32'h40);
    do_call(32'h200);
    chk("call_pc", pc, 32'h200);
    chk("call_ras_not_empty", 32'(ras_empty), 32'd0);
    clear_inputs(); cyc();
    chk("after_call_idle", pc, 32'h204);
    do_ret();
    chk("ret_pc", pc, 32'h44);
    chk("ret_ras_empty", 32'(ras_empty), 32'd1);
    chk("ret_no_underflow", 32'(ras_underflow), 32'd0);
    do_ret();
    chk("ret_empty_pc", pc, 32'h48);
    chk("ret_empty_underflow", 32'(ras_underflow), 32'd1);

    clear_inputs(); call = 1; cyc();
    chk("call_alone_pc", pc, 32'h4C);
    chk("call_alone_no_push", 32'(ras_empty), 32'd1);
    clear_inputs(); ret = 1; jump = 1; call = 1; jump_target = 32'h800; cyc();
    chk("ret_jump_call_pc", pc, 32'h50);
    chk("ret_jump_call_no_push", 32'(ras_empty), 32'd1);

    // Five nested calls from 0x50, 0x1000, 0x2000, 0x3000, 0x4000.
    do_call(32'h1000);
    do_call(32'h2000);
    do_call(32'h3000);
    do_call(32'h4000);
    chk("ras_full_4", 32'(ras_full), 32'd1);
    chk("no_overflow_4", 32'(ras_overflow), 32'd0);
    do_call(32'h5000);
    chk("nested_pc", pc, 32'h5000);
    chk("ras_full_5", 32'(ras_full), 32'd1);
    chk("overflow_5", 32'(ras_overflow), 32'd1);
    do_ret(); chk("nest_ret_e", pc, 32'h4004);
    do_ret(); chk("nest_ret_d", pc, 32'h3004);
    do_ret(); chk("nest_ret_c", pc, 32'h2004);
    do_ret(); chk("nest_ret_b", pc, 32'h1004);
    chk("nest_ras_empty", 32'(ras_empty), 32'd1);

    do_call(32'h600);
    clear_inputs(); exception = 1; stall = 1; jump = 1; call = 1; jump_target = 32'h900; cyc();
    chk("exception_pc", pc, 32'h180);
    chk("exception_ras_kept", 32'(ras_empty), 32'd0);
    do_ret();
    chk("exception_ras_entry", pc, 32'h1008);
    chk("overflow_sticky", 32'(ras_overflow), 32'd1);

    clear_inputs(); jump = 1; jump_target = 32'h203; cyc();
    chk("misaligned_jump_pc", pc, 32'h200);
    chk("misaligned_pulse", 32'(misaligned), 32'd1);
    clear_inputs(); cyc();
    chk("misaligned_drop", 32'(misaligned), 32'd0);
    chk("misaligned_next_pc", pc, 32'h204);
    clear_inputs(); branch = 1; branch_offset = 32'h6; cyc();
    chk("misaligned_branch_pc", pc, 32'h208);
    chk("misaligned_branch", 32'(misaligned), 32'd1);

    clear_inputs(); pc_write = 1; pc_write_value = 32'hFFFF_FFFC; cyc();
    chk("top_pc", pc, 32'hFFFF_FFFC);
    chk("top_pc_plus4", pc_plus4, 32'h0);
    clear_inputs(); cyc();
    chk("wrap_pc", pc, 32'h0);

    cyc(); cyc();
    #2;
    rst_n = 0;
    #1;
    chk("async_reset_pc", pc, 32'h0);
    chk("async_reset_flags", {29'd0, ras_overflow, ras_underflow, misaligned}, 32'd0);
    chk("async_reset_empty", 32'(ras_empty), 32'd1);
    cyc();
    rst_n = 1;
    cyc();
    chk("post_reset_idle", pc, 32'h4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Parametrised next-generation program counter for the MIPS fetch stage. It replaces the fixed 32-bit jump/branch/write PC.
- Adds sequential increment, stall, exception vectoring and a circular return-address stack (RAS) for call/return.
- Feeds the instruction memory address and the IF/ID pc+4 path.

Parameters:
- WIDTH, 32, PC/address width in bits (>= 8).
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset.
- EXC_VECTOR, 32'h0000_0180, PC value loaded on exception.
- RAS_DEPTH, 4, number of return-address stack entries (power of 2, >= 2).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- stall  in  1  hold PC (hazard unit).
- exception  in  1  redirect to EXC_VECTOR.
- jump  in  1  absolute jump request.
- jump_target  in  WIDTH  absolute jump destination.
- call  in  1  qualifies jump as a call: push pc+4 onto the RAS.
- ret  in  1  return: pop the RAS into the PC.
- branch  in  1  relative branch request.
- branch_offset  in  WIDTH  signed byte offset, added to the current pc.
- pc_write  in  1  direct overwrite request.
- pc_write_value  in  WIDTH  overwrite value.
- pc  out  WIDTH  current PC (registered).
- pc_plus4  out  WIDTH  pc + 4 (combinational).
- ras_empty  out  1  RAS holds 0 entries (combinational from count).
- ras_full  out  1  RAS holds RAS_DEPTH entries.
- ras_overflow  out  1  sticky: a push occurred while the RAS was full.
- ras_underflow  out  1  sticky: a pop occurred while the RAS was empty.
- misaligned  out  1  one-cycle pulse: selected target had bits [1:0] != 0.

Behaviour:
- Reset (async assert, sync-safe deassert by the top level) sets:
  - pc = RESET_VECTOR;
  - RAS count = 0, RAS pointer = 0, all RAS entries = 0;
  - ras_overflow = 0, ras_underflow = 0, misaligned = 0.
  - Reset mid-stream discards all pending requests immediately.
- pc updates only on the rising edge of clk. Latency from a request to the new pc is 1 cycle.
- Next-pc priority, highest first, evaluated each cycle:
  1. exception: pc <= EXC_VECTOR. Overrides stall. The RAS is untouched.
  2. stall: pc holds. All other requests are ignored and no RAS change occurs.
  3. ret: pc <= RAS top entry, then pop.
  4. jump: pc <= jump_target. If call=1, push pc_plus4.
  5. branch: pc <= pc + branch_offset, modulo 2^WIDTH, wrap-around permitted.
  6. pc_write: pc <= pc_write_value.
  7. none of the above: pc <= pc_plus4, wrapping to 0 at the top of the address space.
- call without jump has no effect. ret together with jump and call: ret wins, no push.
- Alignment: every selected target from ret, jump, branch or pc_write is loaded with bits [1:0] forced to 00.
  - misaligned pulses high for the cycle after the load when the unforced value had nonzero bits [1:0].
  - EXC_VECTOR and RESET_VECTOR are never checked.
- RAS is a circular buffer with a top pointer and a count saturating at RAS_DEPTH.
  - Push: pointer advances, entry written, count increments.
  - Push when full: the oldest entry is overwritten, count stays RAS_DEPTH, ras_overflow is set.
  - Pop: top entry read, pointer retreats, count decrements.
  - Pop when empty: pc <= pc_plus4 (acts as a no-op increment), pointer unchanged, ras_underflow is set.
  - Sticky flags clear only on reset.
- pc_plus4 = pc + 4 truncated to WIDTH. ras_empty and ras_full are combinational from count.
- No X propagation: unused RAS entries read as 0.

Test Plan:
- Reset then 3 idle cycles, defaults -> pc = 0x0, 0x4, 0x8, 0xC; ras_empty=1.
- At pc=0x100: branch, offset=0xFFFF_FFF0 -> pc=0xF0. Next cycle, branch and pc_write both set -> branch wins. Same cycle as stall -> pc holds.
- At pc=0x40: jump+call, target 0x200 -> pc=0x200, RAS top=0x44. Later ret -> pc=0x44, ras_empty=1. ret again -> pc=0x48, ras_underflow=1.
- RAS_DEPTH=4, 5 nested calls from pcs A..E -> ras_full=1, ras_overflow=1. 4 rets return E+4, D+4, C+4, B+4, after which ras_empty=1.
- exception together with stall and jump -> pc=0x180, RAS count unchanged. Assert rst_n=0 mid-cycle -> pc=RESET_VECTOR immediately, without waiting for a clock edge.
- jump_target=0x203 -> pc=0x200, misaligned pulses exactly 1 cycle. Idle at pc=0xFFFF_FFFC -> pc wraps to 0x0.
